alu_arbiter: RTL
================

# alu_arbiter

Round-robin arbiter and sequencer that shares the single combinational ALU between two requesters. Each requester submits an operand pair and a one-hot ALU_CTRL opcode over a valid/ready handshake. The block registers the operands, drives the ALU for one execute cycle, and captures ALU_OUT/NZCV. It then returns the result with the requester ID over a valid/ready response channel. It sits between the issue logic and the ALU instance.

## Interface
- DATA_W, 32, operand/result width (ALU is 32-bit; other values unsupported)
- CLK  in  1  rising-edge clock
- RST_N  in  1  reset, asynchronous assert, active-low
- REQ0_VALID / REQ1_VALID  in  1  request present
- REQ0_READY / REQ1_READY  out  1  request accepted this cycle
- REQ0_X / REQ1_X  in  DATA_W  operand X
- REQ0_Y / REQ1_Y  in  DATA_W  operand Y
- REQ0_OP / REQ1_OP  in  4  one-hot opcode: 1000 add, 0100 and, 0010 xor, 0001 or
- OP_X  out  DATA_W  to ALU
- OP_Y  out  DATA_W  to ALU
- ALU_CTRL  out  4  to ALU
- ALU_OUT  in  DATA_W  from ALU
- NZCV  in  4  from ALU
- RSP_VALID  out  1  response present
- RSP_READY  in  1  consumer accepts
- RSP_ID  out  1  requester index (0/1)
- RSP_DATA  out  DATA_W  captured result
- RSP_NZCV  out  4  captured flags
- RSP_ERR  out  1  opcode was not exactly one-hot

## Operation
- The FSM has three states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - Grant is computed combinationally from REQx_VALID and the LAST_GNT register.
  - If only one requester is valid, it is granted.
  - If both are valid, the requester not equal to LAST_GNT is granted.
  - REQx_READY = (state==IDLE) && granted x. At most one READY is high. READY never depends on RSP_READY.
  - On a handshake: latch X, Y, OP into OP_X/OP_Y/op_reg; latch ID; set LAST_GNT=ID; go to EXEC.
- EXEC (exactly 1 cycle):
  - If op_reg is legal, ALU_CTRL=op_reg. Otherwise ALU_CTRL=0000.
  - At the clock edge, capture RSP_DATA=ALU_OUT and RSP_NZCV=NZCV unmodified, with RSP_ERR=0. Go to RESP.
  - If op_reg is illegal (zero or more than one bit set), capture RSP_DATA=0, RSP_NZCV=0000, RSP_ERR=1.
- RESP:
  - RSP_VALID=1. RSP_ID, RSP_DATA, RSP_NZCV and RSP_ERR are held stable until the handshake.
  - On RSP_VALID && RSP_READY, return to IDLE.
  - Back-pressure is unbounded.
- ALU_CTRL is 0000 in IDLE and RESP. OP_X/OP_Y hold their last latched values.
- Requests arriving outside IDLE are not accepted. REQx_* must be held by the requester until its READY is seen.

## Timing
- Reset (RST_N low, asynchronous):
  - state=IDLE, LAST_GNT=1 (requester 0 wins the first tie).
  - All outputs 0: REQx_READY, OP_X, OP_Y, ALU_CTRL, RSP_VALID, RSP_ID, RSP_DATA, RSP_NZCV, RSP_ERR.
- Reset mid-operation discards the in-flight op. RSP_VALID drops asynchronously, and no response is produced after release.
- Latency:
  - Accept edge T.
  - EXEC during cycle T+1.
  - RSP_VALID high from T+2.
- Throughput: 1 op per 3 cycles with RSP_READY tied high; the next accept is possible at edge T+3.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1…
- A requester that drops VALID before its grant is simply skipped. LAST_GNT changes only on an accepted request.
- No combinational path from RSP_READY or ALU_OUT to any output. REQx_READY depends only on state, LAST_GNT and REQx_VALID.

## Test plan
- Single add:
  - Stimulus: REQ0 with X=FF000000, Y=F0000000, OP=1000.
  - Required: READY0 at T; ALU_CTRL=1000 during T+1; at T+2, RSP_VALID=1, RSP_ID=0, RSP_DATA=EF000000, RSP_NZCV=1010, RSP_ERR=0.
- Op sweep:
  - Stimulus: same operands through REQ1 with OP=0100, 0010, 0001 in turn.
  - Required: RSP_DATA=F0000000, 0F000000, FF000000 respectively; RSP_ID=1 each time; RSP_NZCV equals the ALU NZCV sampled in EXEC.
- Contention:
  - Stimulus: both requesters valid continuously for 4 ops, REQ0 X=1 Y=2 add, REQ1 X=3 Y=4 add.
  - Required: grant order 0,1,0,1; RSP_DATA alternates 3,7.
- Back-pressure:
  - Stimulus: RSP_READY low for 5 cycles during RESP.
  - Required: response fields stable throughout, both READYs low, no new accept until the cycle after RSP_READY=1.
- Illegal opcode:
  - Stimulus: OP=0110, then OP=0000.
  - Required: ALU_CTRL=0000 in EXEC; RSP_ERR=1, RSP_DATA=0, RSP_NZCV=0000.
- Reset in EXEC or RESP:
  - Stimulus: assert RST_N=0 while an op is in EXEC or RESP.
  - Required: RSP_VALID=0 immediately; after release, the first tie between both requesters grants REQ0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational 32-bit ALU.
// Each accepted op goes through IDLE -> EXEC -> RESP and is returned with its requester ID.
module alu_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req0_valid,
    input  logic              i_req1_valid,
    output logic              o_req0_ready,
    output logic              o_req1_ready,
    input  logic [DATA_W-1:0] i_req0_x,
    input  logic [DATA_W-1:0] i_req1_x,
    input  logic [DATA_W-1:0] i_req0_y,
    input  logic [DATA_W-1:0] i_req1_y,
    input  logic [3:0]        i_req0_op,
    input  logic [3:0]        i_req1_op,
    output logic [DATA_W-1:0] o_op_x,
    output logic [DATA_W-1:0] o_op_y,
    output logic [3:0]        o_alu_ctrl,
    input  logic [DATA_W-1:0] i_alu_out,
    input  logic [3:0]        i_nzcv,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic              o_rsp_id,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic [3:0]        o_rsp_nzcv,
    output logic              o_rsp_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_last_gnt;
    logic [3:0]        r_op;
    logic [DATA_W-1:0] r_op_x;
    logic [DATA_W-1:0] r_op_y;
    logic              r_rsp_id;
    logic [DATA_W-1:0] r_rsp_data;
    logic [3:0]        r_rsp_nzcv;
    logic              r_rsp_err;
    logic              w_gnt_valid;
    logic              w_gnt_id;
    logic              w_op_legal;

    function automatic logic f_is_onehot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

    assign w_op_legal = f_is_onehot(r_op);

    // Grant selection: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_id    = 1'b0;
        if (r_state == ST_IDLE) begin
            if (i_req0_valid && i_req1_valid) begin
                w_gnt_valid = 1'b1;
                w_gnt_id    = ~r_last_gnt;
            end else if (i_req0_valid) begin
                w_gnt_valid = 1'b1;
                w_gnt_id    = 1'b0;
            end else if (i_req1_valid) begin
                w_gnt_valid = 1'b1;
                w_gnt_id    = 1'b1;
            end else begin
                w_gnt_valid = 1'b0;
                w_gnt_id    = 1'b0;
            end
        end else begin
            w_gnt_valid = 1'b0;
            w_gnt_id    = 1'b0;
        end
    end

    assign o_req0_ready = w_gnt_valid && (w_gnt_id == 1'b0);
    assign o_req1_ready = w_gnt_valid && (w_gnt_id == 1'b1);

    // Next-state logic and ALU control decode.
    always_comb begin
        w_state_next = r_state;
        o_alu_ctrl   = 4'b0000;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_valid) begin
                    w_state_next = ST_EXEC;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_EXEC: begin
                w_state_next = ST_RESP;
                if (w_op_legal) begin
                    o_alu_ctrl = r_op;
                end else begin
                    o_alu_ctrl = 4'b0000;
                end
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_RESP;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State and round-robin pointer; the pointer moves only on an accepted request.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_last_gnt <= 1'b1;
        end else begin
            r_state <= w_state_next;
            if (w_gnt_valid) begin
                r_last_gnt <= w_gnt_id;
            end
        end
    end

    // Operand latch on accept, result capture at the end of EXEC.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op       <= 4'b0000;
            r_op_x     <= '0;
            r_op_y     <= '0;
            r_rsp_id   <= 1'b0;
            r_rsp_data <= '0;
            r_rsp_nzcv <= 4'b0000;
            r_rsp_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_valid) begin
                        r_rsp_id <= w_gnt_id;
                        r_op_x   <= w_gnt_id ? i_req1_x  : i_req0_x;
                        r_op_y   <= w_gnt_id ? i_req1_y  : i_req0_y;
                        r_op     <= w_gnt_id ? i_req1_op : i_req0_op;
                    end
                end
                ST_EXEC: begin
                    if (w_op_legal) begin
                        r_rsp_data <= i_alu_out;
                        r_rsp_nzcv <= i_nzcv;
                        r_rsp_err  <= 1'b0;
                    end else begin
                        r_rsp_data <= '0;
                        r_rsp_nzcv <= 4'b0000;
                        r_rsp_err  <= 1'b1;
                    end
                end
                default: begin
                    r_rsp_data <= r_rsp_data;
                end
            endcase
        end
    end

    assign o_op_x      = r_op_x;
    assign o_op_y      = r_op_y;
    assign o_rsp_valid = (r_state == ST_RESP);
    assign o_rsp_id    = r_rsp_id;
    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_nzcv  = r_rsp_nzcv;
    assign o_rsp_err   = r_rsp_err;

endmodule
